// File: rtl/alu_pkg.sv
// Shared op-code constants and controller state encoding for alu_ctrl and its ALU.
// EXEC2 only exists when ALU_CTRL_CARRY_CHAIN_EN is defined.
package alu_pkg;

    localparam logic [3:0] OP_SET = 4'd0;
    localparam logic [3:0] OP_NOT = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_ADC = 4'd4;
    localparam logic [3:0] OP_SBC = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_DONE  = 2'd3
`ifdef ALU_CTRL_CARRY_CHAIN_EN
        ,ST_EXEC2 = 2'd2
`endif
    } ctrl_state_e;

    function automatic logic op_legal(input logic [3:0] op);
        logic ok;
        ok = (op == OP_SET) || (op == OP_NOT) || (op == OP_ADD) || (op == OP_SUB);
`ifdef ALU_CTRL_CARRY_CHAIN_EN
        ok = ok || (op == OP_ADC) || (op == OP_SBC);
`endif
        return ok;
    endfunction

    // Carry-chain ops run on the plain ALU add/subtract in both passes.
    function automatic logic [3:0] alu_op_for(input logic [3:0] op);
        logic [3:0] r;
        r = op;
        if (op == OP_ADC) r = OP_ADD;
        if (op == OP_SBC) r = OP_SUB;
        return r;
    endfunction

endpackage

// File: rtl/alu_ctrl_alu.sv
// Combinational 8-bit ALU: SET/NOT/ADD/SUB with carry (borrow for SUB), zero and sign.
module alu
    import alu_pkg::*;
(
    input  logic [3:0] op_i,
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] y_o,
    output logic       c_o,
    output logic       z_o,
    output logic       s_o
);

    logic [8:0] res;

    always_comb begin
        res = {1'b0, a_i};
        case (op_i)
            OP_SET:  res = {1'b0, b_i};
            OP_NOT:  res = {1'b0, ~a_i};
            OP_ADD:  res = {1'b0, a_i} + {1'b0, b_i};
            OP_SUB:  res = {1'b0, a_i} - {1'b0, b_i};
            default: res = {1'b0, a_i};
        endcase
    end

    assign y_o = res[7:0];
    assign c_o = res[8];
    assign z_o = (res[7:0] == 8'h00);
    assign s_o = res[7];

endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl: command sequencer for the 8-bit ALU; owns the register file and C/Z/S flags.
// Define ALU_CTRL_CARRY_CHAIN_EN to build ADC/SBC as a two-pass execute through EXEC2.
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int REGS = 4,
    localparam int RW = $clog2(REGS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_op,
    input  logic [RW-1:0] cmd_dst,
    input  logic [RW-1:0] cmd_src,
    input  logic          cmd_use_imm,
    input  logic [7:0]    cmd_imm,
    output logic          done,
    output logic          err,
    output logic          flag_c,
    output logic          flag_z,
    output logic          flag_s,
    input  logic [RW-1:0] rd_sel,
    output logic [7:0]    rd_data
);

    ctrl_state_e   state_q;
    logic [3:0]    op_q;
    logic [RW-1:0] dst_q;
    logic [7:0]    a_q;
    logic [7:0]    b_q;
    logic [7:0]    regs_q [REGS];
    logic          done_q;
    logic          err_q;
    logic          fc_q;
    logic          fz_q;
    logic          fs_q;
`ifdef ALU_CTRL_CARRY_CHAIN_EN
    logic [7:0]    t_q;
    logic          c1_q;
`endif

    logic [3:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_y;
    logic       alu_c;
    logic       alu_z;
    logic       alu_s;

    always_comb begin
        alu_op = alu_op_for(op_q);
        alu_a  = a_q;
        alu_b  = b_q;
`ifdef ALU_CTRL_CARRY_CHAIN_EN
        // Second pass folds in the carry held from before this command.
        if (state_q == ST_EXEC2) begin
            alu_a = t_q;
            alu_b = {7'b0, fc_q};
        end
`endif
    end

    alu u_alu (
        .op_i (alu_op),
        .a_i  (alu_a),
        .b_i  (alu_b),
        .y_o  (alu_y),
        .c_o  (alu_c),
        .z_o  (alu_z),
        .s_o  (alu_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            op_q    <= 4'd0;
            dst_q   <= '0;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            fc_q    <= 1'b0;
            fz_q    <= 1'b0;
            fs_q    <= 1'b0;
`ifdef ALU_CTRL_CARRY_CHAIN_EN
            t_q     <= 8'h00;
            c1_q    <= 1'b0;
`endif
            for (int i = 0; i < REGS; i++) regs_q[i] <= 8'h00;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_op;
                        dst_q   <= cmd_dst;
                        a_q     <= regs_q[cmd_dst];
                        b_q     <= cmd_use_imm ? cmd_imm : regs_q[cmd_src];
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (!op_legal(op_q)) begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end
`ifdef ALU_CTRL_CARRY_CHAIN_EN
                    else if ((op_q == OP_ADC) || (op_q == OP_SBC)) begin
                        t_q     <= alu_y;
                        c1_q    <= alu_c;
                        state_q <= ST_EXEC2;
                    end
`endif
                    else begin
                        regs_q[dst_q] <= alu_y;
                        if ((op_q == OP_ADD) || (op_q == OP_SUB)) begin
                            fc_q <= alu_c;
                            fz_q <= alu_z;
                            fs_q <= alu_s;
                        end
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
`ifdef ALU_CTRL_CARRY_CHAIN_EN
                ST_EXEC2: begin
                    regs_q[dst_q] <= alu_y;
                    fc_q    <= c1_q | alu_c;
                    fz_q    <= alu_z;
                    fs_q    <= alu_s;
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
`endif
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign rd_data   = regs_q[rd_sel];
    assign done      = done_q;
    assign err       = err_q;
    assign flag_c    = fc_q;
    assign flag_z    = fz_q;
    assign flag_s    = fs_q;

endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Sequencing front-end for the 8-bit ALU. Accepts one register-level command per handshake, reads operands from a small internal register file, drives the ALU operation code, and writes the result back. It latches the carry, zero and sign flags and raises a one-cycle completion pulse. It sits between the instruction decoder and the ALU and owns architectural register and flag state.

## Interface
- `REGS`, 4: register-file depth, power of two, ≥2; index width `RW = $clog2(REGS)`.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_op` in 4: 0 SET, 1 NOT, 2 ADD, 3 SUB, 4 ADC, 5 SBC; all other codes are illegal.
- `cmd_dst` in RW: destination register; also operand A.
- `cmd_src` in RW: source register for operand B.
- `cmd_use_imm` in 1: when 1, B = `cmd_imm`, not R[src].
- `cmd_imm` in 8: immediate operand.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: high together with `done` for an illegal op.
- `flag_c`, `flag_z`, `flag_s` out 1 each: latched flags.
- `rd_sel` in RW: debug readback select.
- `rd_data` out 8: combinational R[rd_sel].

## Operation
- **Command capture.** A command is accepted on the rising edge where `cmd_valid & cmd_ready`. At that edge the block captures op, dst, A = R[dst], and B.
- **State machine.** States are IDLE, EXEC, EXEC2, DONE.
  - IDLE → EXEC on accept.
  - EXEC → EXEC2 for ADC/SBC; otherwise EXEC → DONE.
  - EXEC2 → DONE.
  - DONE → IDLE, unconditionally.
- **SET:** R[dst] ← B. Flags unchanged.
- **NOT:** R[dst] ← ~A. Flags unchanged.
- **ADD:** {C, R[dst]} ← A + B, as 9-bit unsigned. Z = (result == 0). S = result[7].
- **SUB:** {C, R[dst]} ← A − B. C is the borrow, i.e. 1 when A < B unsigned. Z and S as for ADD.
- **ADC.**
  - EXEC computes T = A + B (ALU ADD) and latches c1.
  - EXEC2 computes T + {7'b0, flag_c}, using the flag value held before the command, and yields c2.
  - C = c1 | c2. Z and S come from the final result.
- **SBC.** Same two-pass scheme using SUB: T = A − B, then T − flag_c. C = b1 | b2.
- **Write-back timing.** The register write and the flag update happen on the edge that leaves the last execute state (EXEC or EXEC2). They are visible in DONE.
- **Illegal op.** No register or flag change. The block walks EXEC → DONE with `err` = 1.
- **dst == src.** Legal; operand B reads the pre-write value.
- **Commands outside IDLE.** `cmd_valid` outside IDLE is ignored; the command must be held until accepted.
- **Reset (any time, including mid-command).**
  - All registers = 0x00.
  - `flag_c`/`flag_z`/`flag_s` = 0.
  - State = IDLE, so `cmd_ready` = 1 while reset is asserted.
  - `done` = 0, `err` = 0.
  - Any in-flight command is discarded with no write.

## Timing
- **Latency.** With accept at edge N:
  - SET/NOT/ADD/SUB/illegal: `done` is high during the cycle after edge N+1.
  - ADC/SBC: `done` is high during the cycle after edge N+2.
- **Throughput.** `cmd_ready` is low from the cycle after accept through DONE. It returns high in the cycle after `done`. This gives one command per 3 cycles (4 for ADC/SBC).
- **Registered outputs.** `done`, `err` and the flags are registered. `cmd_ready` and `rd_data` are combinational from state and register contents.
- **Widths.** All arithmetic is 8-bit modulo 256; carry/borrow is the 9th bit.

## Configuration
- **`ALU_CTRL_CARRY_CHAIN_EN` defined:** ADC/SBC are implemented as above, and EXEC2 exists.
- **Macro undefined:** ops 4 and 5 are illegal (`err` = 1, no state change) and the EXEC2 state is not built. All other behaviour is identical.

## Structure
- **Package `alu_pkg`:** the 4-bit op-code constants (SET, NOT, ADD, SUB, ADC, SBC) and the controller state enum typedef. The decoder and the ALU share the same op constants.
- **Sub-module:** one `alu` instance, driven by the controller-muxed A, B and operation code. Its C/Z/S outputs are sampled only in the execute states.
- **Register file:** stays inside `alu_ctrl`; no separate module.

## Test plan
- **Reset, then SET:** SET dst=1, imm=0x5A → R1 = 0x5A; flags stay 0; `done` on the second cycle after accept; `cmd_ready` low for 2 cycles.
- **ADD wrap:** R0 = 0xFF; ADD dst=0, imm=0x01 → R0 = 0x00, C=1, Z=1, S=0.
- **SUB borrow:** R2 = 0x10; SUB dst=2, imm=0x20 → R2 = 0xF0, C=1, Z=0, S=1. Then NOT dst=2 → R2 = 0x0F, flags unchanged.
- **ADC (macro on):** with flag_c=1, R0 = 0x7F; ADC dst=0, imm=0x00 → R0 = 0x80, C=0, S=1, `done` 3 cycles after accept. With the macro off, the same op → `err` = 1, R0 unchanged.
- **Illegal op and back-pressure:** op=0xF → `done` & `err`, no change. `cmd_valid` held through busy cycles → accepted exactly once.
- **Mid-command reset:** assert `reset_n` = 0 in EXEC of an ADD → no write, all registers/flags 0, `done` never pulses, `cmd_ready` = 1.
